// File: rtl/wb_uart_bridge_pkg.sv
// Shared constants and state encoding for the UART-driven Wishbone master.
package wb_uart_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RSP_OK    = 8'h06;
  localparam logic [7:0] RSP_FAIL  = 8'h15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    BUS   = 3'd3,
    RETRY = 3'd4,
    RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/wb_uart_bridge.sv
// Host byte stream -> single-beat Wishbone cycle -> status/read-data reply bytes.
// Optional bus watchdog: define WB_UART_BRIDGE_TIMEOUT_EN.
module wb_uart_bridge
  import wb_uart_bridge_pkg::*;
#(
  parameter int RETRY_MAX      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_stb_i,
  output logic [7:0]  tx_dat_o,
  output logic        tx_stb_o,
  input  logic        tx_busy_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        busy_o
);

  localparam int RW = $clog2(RETRY_MAX + 1) + 1;

  state_t        r_state, w_next;
  logic          r_we;
  logic [1:0]    r_cnt;
  logic [31:0]   r_adr, r_dat, r_shift;
  logic [RW-1:0] r_retry;
  logic [2:0]    r_tx_left;
  logic          r_tx_stb;
  logic [7:0]    r_tx_dat;

  logic w_cmd_ok, w_rx_last, w_emit, w_retry_ok, w_fail, w_tmo;

  assign w_cmd_ok   = rx_stb_i && (rx_dat_i == CMD_WRITE || rx_dat_i == CMD_READ);
  assign w_rx_last  = rx_stb_i && (r_cnt == 2'd3);
  assign w_emit     = (r_state == RESP) && !r_tx_stb && !tx_busy_i;
  assign w_retry_ok = (int'(r_retry) < RETRY_MAX);
  // Failure exits of BUS; a retryable rty outranks the watchdog.
  assign w_fail     = !wb_ack_i && (wb_err_i || (wb_rty_i ? !w_retry_ok : w_tmo));

`ifdef WB_UART_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wdog;

  // Cleared outside BUS, so every entry (fresh or after RETRY) starts at zero.
  always_ff @(posedge clk_i) begin
    if (!rst_i || r_state != BUS) r_wdog <= '0;
    else                          r_wdog <= r_wdog + 1'b1;
  end
  assign w_tmo = (r_state == BUS) && (int'(r_wdog) == TIMEOUT_CYCLES - 1);
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_cmd_ok) w_next = ADDR;
      ADDR:  if (w_rx_last) w_next = r_we ? DATA : BUS;
      DATA:  if (w_rx_last) w_next = BUS;
      BUS: begin
        if (wb_ack_i || wb_err_i)  w_next = RESP;
        else if (wb_rty_i)         w_next = w_retry_ok ? RETRY : RESP;
        else if (w_tmo)            w_next = RESP;
      end
      RETRY: w_next = BUS;
      RESP:  if (w_emit && r_tx_left == 3'd1) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    wb_cyc_o = (r_state == BUS);
    wb_stb_o = (r_state == BUS);
    busy_o   = (r_state != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_shift   <= '0;
      r_retry   <= '0;
      r_tx_left <= '0;
      r_tx_stb  <= 1'b0;
      r_tx_dat  <= '0;
    end else begin
      r_tx_stb <= 1'b0;
      case (r_state)
        IDLE: if (w_cmd_ok) begin
          r_we    <= (rx_dat_i == CMD_WRITE);
          r_cnt   <= '0;
          r_retry <= '0;
        end
        ADDR: if (rx_stb_i) begin
          r_adr <= {r_adr[23:0], rx_dat_i};
          r_cnt <= r_cnt + 2'd1;
        end
        DATA: if (rx_stb_i) begin
          r_dat <= {r_dat[23:0], rx_dat_i};
          r_cnt <= r_cnt + 2'd1;
        end
        BUS: begin
          if (wb_ack_i) begin
            r_shift   <= r_we ? {RSP_OK, 24'h0} : wb_dat_i;
            r_tx_left <= r_we ? 3'd1 : 3'd4;
          end else if (w_fail) begin
            r_shift   <= {RSP_FAIL, 24'h0};
            r_tx_left <= 3'd1;
          end
        end
        RETRY: r_retry <= r_retry + 1'b1;
        RESP: if (w_emit) begin
          r_tx_stb  <= 1'b1;
          r_tx_dat  <= r_shift[31:24];
          r_shift   <= {r_shift[23:0], 8'h00};
          r_tx_left <= r_tx_left - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_we_o  = r_we;
  assign wb_sel_o = 4'hF;
  assign tx_stb_o = r_tx_stb;
  assign tx_dat_o = r_tx_dat;

endmodule
